// File: rtl/lms_tap_sequencer_if.sv
// rtl/lms_tap_sequencer_if.sv - core and RAM side signal bundle of the LMS tap sequencer
`timescale 1ns/1ps
interface lms_tap_sequencer_if #(
  parameter int AW = 4
);
  logic          fir_go;
  logic [15:0]   sample_in;
  logic [31:0]   adjust_in;
  logic          update_en;
  logic [AW-1:0] x_addr;
  logic          x_rd_en;
  logic          x_wr_en;
  logic [15:0]   x_wdata;
  logic [15:0]   x_rdata;
  logic [AW-1:0] w_addr;
  logic          w_rd_en;
  logic          w_wr_en;
  logic [15:0]   w_wdata;
  logic [15:0]   w_rdata;
  logic [15:0]   y_out;
  logic          fir_done;
  logic          busy;
  logic          go_dropped;

  modport master (
    output fir_go, sample_in, adjust_in, update_en, x_rdata, w_rdata,
    input  x_addr, x_rd_en, x_wr_en, x_wdata, w_addr, w_rd_en, w_wr_en, w_wdata,
    input  y_out, fir_done, busy, go_dropped
  );

  modport slave (
    input  fir_go, sample_in, adjust_in, update_en, x_rdata, w_rdata,
    output x_addr, x_rd_en, x_wr_en, x_wdata, w_addr, w_rd_en, w_wr_en, w_wdata,
    output y_out, fir_done, busy, go_dropped
  );
endinterface

// File: rtl/lms_tap_sequencer.sv
// rtl/lms_tap_sequencer.sv - time-multiplexed FIR MAC and in-place LMS weight update sequencer
`timescale 1ns/1ps
module lms_tap_sequencer #(
  parameter int TAPS  = 16,
  parameter int AW    = 4,
  parameter int FRAC  = 15,
  parameter int ACC_W = 40
) (
  input logic               clk,
  input logic               rst,
  lms_tap_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_WR_X, S_FILT, S_DRAIN, S_DONE, S_UPD_RD, S_UPD_WR
  } state_t;

  localparam logic [AW-1:0]           LAST_K = AW'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] Y_MAX  = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] Y_MIN  = -ACC_W'(32768);
  localparam logic signed [47:0]      W_MAX  = 48'(32767);
  localparam logic signed [47:0]      W_MIN  = -48'(32768);

  state_t                  r_state;
  logic [AW-1:0]           r_head;
  logic [AW-1:0]           r_k;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [31:0]      r_adjust;
  logic                    r_upd;
  logic [AW-1:0]           r_x_addr;
  logic [AW-1:0]           r_w_addr;
  logic                    r_x_rd_en;
  logic                    r_x_wr_en;
  logic                    r_w_rd_en;
  logic                    r_w_wr_en;
  logic [15:0]             r_x_wdata;
  logic [15:0]             r_y_out;
  logic                    r_fir_done;
  logic                    r_busy;
  logic                    r_go_dropped;

  logic [AW-1:0]           w_k_next;
  logic signed [31:0]      w_prod;
  logic signed [ACC_W-1:0] w_acc_sum;
  logic signed [ACC_W-1:0] w_y_shift;
  logic [15:0]             w_y_sat;
  logic signed [47:0]      w_delta;
  logic signed [47:0]      w_w_sum;
  logic [15:0]             w_w_sat;

  assign w_k_next  = r_k + AW'(1);
  assign w_prod    = 32'($signed(bus.x_rdata)) * 32'($signed(bus.w_rdata));
  assign w_acc_sum = r_acc + ACC_W'(w_prod);
  assign w_y_shift = w_acc_sum >>> FRAC;
  assign w_delta   = (48'(r_adjust) * 48'($signed(bus.x_rdata))) >>> (2 * FRAC);
  assign w_w_sum   = 48'($signed(bus.w_rdata)) + w_delta;

  always_comb begin
    w_y_sat = w_y_shift[15:0];
    if (w_y_shift > Y_MAX)      w_y_sat = 16'h7FFF;
    else if (w_y_shift < Y_MIN) w_y_sat = 16'h8000;
  end

  always_comb begin
    w_w_sat = w_w_sum[15:0];
    if (w_w_sum > W_MAX)      w_w_sat = 16'h7FFF;
    else if (w_w_sum < W_MIN) w_w_sat = 16'h8000;
  end

  // Updated weight depends on the read data returned in the UPD_WR cycle itself
  assign bus.w_wdata    = w_w_sat;
  assign bus.x_addr     = r_x_addr;
  assign bus.x_rd_en    = r_x_rd_en;
  assign bus.x_wr_en    = r_x_wr_en;
  assign bus.x_wdata    = r_x_wdata;
  assign bus.w_addr     = r_w_addr;
  assign bus.w_rd_en    = r_w_rd_en;
  assign bus.w_wr_en    = r_w_wr_en;
  assign bus.y_out      = r_y_out;
  assign bus.fir_done   = r_fir_done;
  assign bus.busy       = r_busy;
  assign bus.go_dropped = r_go_dropped;

  // Strobes are registered on the edge entering the state that owns them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_head       <= '0;
      r_k          <= '0;
      r_acc        <= '0;
      r_adjust     <= '0;
      r_upd        <= 1'b0;
      r_x_addr     <= '0;
      r_w_addr     <= '0;
      r_x_rd_en    <= 1'b0;
      r_x_wr_en    <= 1'b0;
      r_w_rd_en    <= 1'b0;
      r_w_wr_en    <= 1'b0;
      r_x_wdata    <= '0;
      r_y_out      <= '0;
      r_fir_done   <= 1'b0;
      r_busy       <= 1'b0;
      r_go_dropped <= 1'b0;
    end else begin
      r_x_rd_en    <= 1'b0;
      r_x_wr_en    <= 1'b0;
      r_w_rd_en    <= 1'b0;
      r_w_wr_en    <= 1'b0;
      r_fir_done   <= 1'b0;
      r_go_dropped <= bus.fir_go && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (bus.fir_go) begin
            r_adjust  <= $signed(bus.adjust_in);
            r_upd     <= bus.update_en;
            r_acc     <= '0;
            r_k       <= '0;
            r_busy    <= 1'b1;
            r_x_wr_en <= 1'b1;
            r_x_addr  <= r_head;
            r_x_wdata <= bus.sample_in;
            r_state   <= S_WR_X;
          end
        end
        S_WR_X: begin
          r_x_rd_en <= 1'b1;
          r_w_rd_en <= 1'b1;
          r_x_addr  <= r_head;
          r_w_addr  <= '0;
          r_state   <= S_FILT;
        end
        S_FILT: begin
          if (r_k != '0) r_acc <= w_acc_sum;
          if (r_k == LAST_K) begin
            r_state <= S_DRAIN;
          end else begin
            r_k       <= w_k_next;
            r_x_rd_en <= 1'b1;
            r_w_rd_en <= 1'b1;
            r_x_addr  <= r_head - w_k_next;
            r_w_addr  <= w_k_next;
          end
        end
        S_DRAIN: begin
          r_acc      <= w_acc_sum;
          r_y_out    <= w_y_sat;
          r_fir_done <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          if (r_upd) begin
            r_k       <= '0;
            r_x_rd_en <= 1'b1;
            r_w_rd_en <= 1'b1;
            r_x_addr  <= r_head;
            r_w_addr  <= '0;
            r_state   <= S_UPD_RD;
          end else begin
            r_head  <= r_head + AW'(1);
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_UPD_RD: begin
          r_w_wr_en <= 1'b1;
          r_w_addr  <= r_k;
          r_state   <= S_UPD_WR;
        end
        S_UPD_WR: begin
          if (r_k == LAST_K) begin
            r_head  <= r_head + AW'(1);
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_k       <= w_k_next;
            r_x_rd_en <= 1'b1;
            r_w_rd_en <= 1'b1;
            r_x_addr  <= r_head - w_k_next;
            r_w_addr  <= w_k_next;
            r_state   <= S_UPD_RD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lms_tap_sequencer.sv
// tb/tb_lms_tap_sequencer.sv - directed scoreboard bench for lms_tap_sequencer with TAPS=4
`timescale 1ns/1ps
module tb_lms_tap_sequencer;
  localparam int TAPS = 4;
  localparam int AW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lms_tap_sequencer_if #(.AW(AW)) bus();
  lms_tap_sequencer #(.TAPS(TAPS), .AW(AW), .FRAC(15), .ACC_W(40)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0]   x_mem [TAPS];
  logic [15:0]   w_mem [TAPS];
  logic          pl_x_en = 1'b0;
  logic          pl_w_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [15:0]   pl_data = '0;

  // Synchronous single-port RAMs plus a preload port for the bench
  always @(posedge clk) begin
    if (pl_x_en) x_mem[pl_addr] <= pl_data;
    if (pl_w_en) w_mem[pl_addr] <= pl_data;
    if (bus.x_wr_en) x_mem[bus.x_addr] <= bus.x_wdata;
    if (bus.w_wr_en) w_mem[bus.w_addr] <= bus.w_wdata;
    if (bus.x_rd_en) bus.x_rdata <= x_mem[bus.x_addr];
    if (bus.w_rd_en) bus.w_rdata <= w_mem[bus.w_addr];
  end

  int wr_log[$];
  int rd_log[$];
  int w_wr_cnt = 0;
  int done_cnt = 0;
  int drop_cnt = 0;

  always @(negedge clk) begin
    if (bus.x_wr_en) wr_log.push_back(int'(bus.x_addr));
    if (bus.x_rd_en) rd_log.push_back(int'(bus.x_addr));
    if (bus.w_wr_en) w_wr_cnt <= w_wr_cnt + 1;
    if (bus.fir_done) done_cnt <= done_cnt + 1;
    if (bus.go_dropped) drop_cnt <= drop_cnt + 1;
  end

  logic signed [15:0] m_x [TAPS];
  logic signed [15:0] m_w [TAPS];
  int                 m_head = 0;
  logic [15:0]        exp_q[$];

  function automatic logic [15:0] sat16(input longint v);
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  task automatic model_go(input logic [15:0] s, input logic [31:0] a, input logic u);
    int     idx;
    longint acc;
    longint d;
    acc = 0;
    m_x[m_head] = s;
    for (int k = 0; k < TAPS; k++) begin
      idx = (m_head - k) & (TAPS - 1);
      acc += longint'(m_x[idx]) * longint'(m_w[k]);
    end
    exp_q.push_back(sat16(acc >>> 15));
    if (u) begin
      for (int k = 0; k < TAPS; k++) begin
        idx = (m_head - k) & (TAPS - 1);
        d = (longint'($signed(a)) * longint'(m_x[idx])) >>> 30;
        m_w[k] = sat16(longint'(m_w[k]) + d);
      end
    end
    m_head = (m_head + 1) & (TAPS - 1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic is_w, input int addr, input logic [15:0] d);
    @(posedge clk); #1;
    pl_addr = AW'(addr);
    pl_data = d;
    pl_x_en = !is_w;
    pl_w_en = is_w;
    @(posedge clk); #1;
    pl_x_en = 1'b0;
    pl_w_en = 1'b0;
    if (is_w) m_w[addr] = d;
    else      m_x[addr] = d;
  endtask

  task automatic start(input logic [15:0] s, input logic [31:0] a, input logic u);
    @(posedge clk); #1;
    bus.fir_go    = 1'b1;
    bus.sample_in = s;
    bus.adjust_in = a;
    bus.update_en = u;
    model_go(s, a, u);
    @(posedge clk); #1;
    bus.fir_go = 1'b0;
    chk("busy_rise", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, output int n, output logic [15:0] y);
    logic [15:0] e;
    n = 0;
    y = '0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.fir_done && n < 40);
    if (bus.fir_done && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      y = bus.y_out;
      chk({tag, "_y"}, 32'(bus.y_out), 32'(e));
    end else begin
      chk({tag, "_done_timeout"}, 32'(bus.fir_done), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          nb;
    int          s_done;
    int          s_drop;
    int          s_wcnt;
    logic [15:0] y;
    logic [15:0] imp_s [5];
    logic [15:0] imp_y [5];
    int          rd5 [$];
    imp_s = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    imp_y = '{16'h3FFF, 16'h1FFF, 16'h0FFF, 16'h07FF, 16'h0000};

    bus.fir_go    = 1'b0;
    bus.sample_in = '0;
    bus.adjust_in = '0;
    bus.update_en = 1'b0;

    for (int i = 0; i < TAPS; i++) begin
      preload(1'b0, i, 16'h0000);
      preload(1'b1, i, 16'h0000);
    end
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_fir_done", 32'(bus.fir_done), 32'd0);
    chk("rst_y_out", 32'(bus.y_out), 32'd0);
    chk("rst_x_wr_en", 32'(bus.x_wr_en), 32'd0);
    chk("rst_x_addr", 32'(bus.x_addr), 32'd0);
    chk("rst_go_dropped", 32'(bus.go_dropped), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Impulse response through the weight vector
    preload(1'b1, 0, 16'h4000);
    preload(1'b1, 1, 16'h2000);
    preload(1'b1, 2, 16'h1000);
    preload(1'b1, 3, 16'h0800);
    wr_log.delete();
    for (int i = 0; i < 5; i++) begin
      start(imp_s[i], 32'd0, 1'b0);
      wait_done($sformatf("impulse%0d", i), n, y);
      chk($sformatf("impulse%0d_const", i), 32'(y), 32'(imp_y[i]));
      chk($sformatf("impulse%0d_latency", i), 32'(n), 32'd7);
    end
    chk("first_write_addr", (wr_log.size() > 0) ? 32'(wr_log[0]) : 32'hFFFF_FFFF, 32'd0);

    // Positive and negative saturation
    for (int i = 0; i < TAPS; i++) preload(1'b1, i, 16'h7FFF);
    for (int i = 0; i < 4; i++) begin
      start(16'h7FFF, 32'd0, 1'b0);
      wait_done($sformatf("satpos%0d", i), n, y);
    end
    chk("satpos_const", 32'(y), 32'h7FFF);
    for (int i = 0; i < 4; i++) begin
      start(16'h8000, 32'd0, 1'b0);
      wait_done($sformatf("satneg%0d", i), n, y);
    end
    chk("satneg_const", 32'(y), 32'h8000);

    // Weight update pass
    for (int i = 0; i < TAPS; i++) begin
      preload(1'b0, i, 16'h0000);
      preload(1'b1, i, 16'h0000);
    end
    s_wcnt = w_wr_cnt;
    start(16'h4000, 32'h2000_0000, 1'b1);
    wait_done("update", n, y);
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      nb++;
    end
    chk("update_busy_cycles", 32'(nb), 32'd8);
    chk("update_w_writes", 32'(w_wr_cnt - s_wcnt), 32'd4);
    chk("update_w0", 32'(w_mem[0]), 32'h2000);
    for (int i = 1; i < TAPS; i++) chk($sformatf("update_w%0d", i), 32'(w_mem[i]), 32'h0000);
    for (int i = 0; i < TAPS; i++) chk($sformatf("update_model_w%0d", i), 32'(w_mem[i]), 32'(m_w[i]));

    // Second fir_go while busy is dropped
    s_done = done_cnt;
    s_drop = drop_cnt;
    wr_log.delete();
    start(16'h4000, 32'd0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    bus.fir_go    = 1'b1;
    bus.sample_in = 16'h1111;
    @(posedge clk); #1;
    bus.fir_go = 1'b0;
    @(negedge clk);
    chk("collision_go_dropped", 32'(bus.go_dropped), 32'd1);
    wait_done("collision", n, y);
    repeat (12) @(negedge clk);
    chk("collision_done_count", 32'(done_cnt - s_done), 32'd1);
    chk("collision_drop_count", 32'(drop_cnt - s_drop), 32'd1);
    chk("collision_x_writes", 32'(wr_log.size()), 32'd1);

    // Asynchronous reset in the middle of a sample
    start(16'h1234, 32'd0, 1'b0);
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_x_rd_en", 32'(bus.x_rd_en), 32'd0);
    chk("midrst_w_rd_en", 32'(bus.w_rd_en), 32'd0);
    chk("midrst_x_addr", 32'(bus.x_addr), 32'd0);
    chk("midrst_y_out", 32'(bus.y_out), 32'd0);
    exp_q.delete();
    m_head = 0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Head pointer wrap across six samples
    wr_log.delete();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) rd_log.delete();
      start(16'($urandom_range(0, 65535)), 32'd0, 1'b0);
      wait_done($sformatf("wrap%0d", i), n, y);
      if (i == 4) rd5 = rd_log;
    end
    chk("wrap_write_count", 32'(wr_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < wr_log.size(); i++)
      chk($sformatf("wrap_write%0d", i), 32'(wr_log[i]), 32'(i % TAPS));
    chk("wrap_read_count", 32'(rd5.size()), 32'd4);
    for (int i = 0; i < 4 && i < rd5.size(); i++)
      chk($sformatf("wrap_read%0d", i), 32'(rd5[i]), 32'((TAPS - i) % TAPS));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lms_tap_sequencer.md
Name: lms_tap_sequencer

Overview:
Time-multiplexed tap controller for the adaptive filter. On each fir_go from the core FSM it runs one shared MAC across TAPS taps, and drives the sample delay-line RAM and the weight RAM. It returns the filter output with a fir_done pulse, then optionally runs an in-place LMS weight-update pass using the core's weight_adjust value.

Parameters:
TAPS, 16, number of filter taps; must be a power of two.
AW, 4, RAM address width; must equal log2(TAPS).
FRAC, 15, fractional bits of samples and weights (Q1.15).
ACC_W, 40, accumulator width; must be at least 32+AW.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
fir_go  in  1  start pulse; sampled only in IDLE
sample_in  in  16  signed new input sample; latched when fir_go is accepted
adjust_in  in  32  signed Q2.30 weight adjustment; latched when fir_go is accepted
update_en  in  1  run the update pass for this sample; latched when fir_go is accepted
x_addr  out  AW  sample RAM address
x_rd_en  out  1  sample RAM read strobe
x_wr_en  out  1  sample RAM write strobe
x_wdata  out  16  sample RAM write data
x_rdata  in  16  sample RAM read data; valid the cycle after x_rd_en
w_addr  out  AW  weight RAM address
w_rd_en  out  1  weight RAM read strobe
w_wr_en  out  1  weight RAM write strobe
w_wdata  out  16  weight RAM write data
w_rdata  in  16  weight RAM read data; valid the cycle after w_rd_en
y_out  out  16  signed filter output; held until the next DONE
fir_done  out  1  one-cycle pulse; y_out is valid in the same cycle
busy  out  1  high whenever state is not IDLE
go_dropped  out  1  one-cycle pulse when fir_go arrives while busy

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is asynchronous and active-high.
- Reset clears all outputs, head pointer, accumulator, latched inputs and k to 0, and forces state to IDLE. Reset mid-operation abandons the sample immediately. RAM contents are not touched.
- All outputs are registered. Strobes default to 0 in every cycle unless a state drives them.
- IDLE:
  - On fir_go: latch sample_in, adjust_in and update_en; clear acc; set k=0; go to WR_X.
  - fir_go in any other state is ignored and go_dropped pulses for that cycle.
- WR_X (1 cycle): x_wr_en=1, x_addr=head, x_wdata=latched sample. Go to FILT.
- FILT (TAPS cycles, k=0..TAPS-1):
  - Drive x_rd_en=w_rd_en=1, x_addr=(head-k) mod 2^AW, w_addr=k.
  - From the second FILT cycle on, add sign-extended (x_rdata*w_rdata) to acc (32-bit product).
  - After k=TAPS-1, go to DRAIN.
- DRAIN (1 cycle): accumulate the last product. Go to DONE.
- DONE (1 cycle):
  - y_out = acc>>>FRAC (arithmetic shift, floor), saturated to [-32768, 32767]; fir_done=1.
  - If update_en was latched: k=0, go to UPD_RD. Otherwise head<=head+1 (wraps TAPS-1 to 0) and go to IDLE.
- UPD_RD (1 cycle per tap): x_rd_en=w_rd_en=1, x_addr=(head-k) mod 2^AW, w_addr=k. Go to UPD_WR.
- UPD_WR (1 cycle per tap):
  - delta = (adjust*x_rdata)>>>(2*FRAC), using a 48-bit product.
  - w_wdata = sat16(w_rdata + delta); w_wr_en=1; w_addr=k.
  - If k=TAPS-1: head<=head+1 and go to IDLE. Otherwise k<=k+1 and go to UPD_RD.
- Latency, counting fir_go sampled at edge E0:
  - fir_done is high in the cycle after edge E0+TAPS+2, i.e. TAPS+3 cycles after acceptance.
  - With update, IDLE is re-entered 2*TAPS cycles after DONE.
- busy rises in the cycle after acceptance and falls on the edge that enters IDLE. The next fir_go is accepted in the first IDLE cycle.
- Tap k=0 always reads the sample just written.
- Write-then-read of the same sample address in consecutive cycles is legal (1-cycle synchronous RAM).
- Accumulator: ACC_W bits, no internal overflow for legal TAPS. Saturation is applied only at y_out.

Test Plan (TAPS=4, AW=2):
- Reset: assert rst mid-cycle -> all outputs 0 immediately, busy=0. After release, first fir_go writes x_addr=0.
- Impulse: weights {0x4000,0x2000,0x1000,0x0800}, update_en=0, samples 0x7FFF,0,0,0,0 -> y_out=0x3FFF,0x1FFF,0x0FFF,0x07FF,0x0000. fir_done occurs 7 cycles after each fir_go.
- Saturation: all weights 0x7FFF, four samples 0x7FFF -> 4th y_out=0x7FFF. Samples 0x8000 with the same weights -> y_out=0x8000.
- Update: weights 0, adjust_in=0x2000_0000, sample 0x4000 with update_en=1 -> w[0]=0x2000 and w[1..3]=0. busy stays high 8 cycles after fir_done.
- Collision: fir_go pulses at cycles 0 and 3 -> single fir_done, go_dropped=1 at cycle 3, no extra RAM writes.
- Wrap: 6 consecutive samples -> x_wr_en addresses 0,1,2,3,0,1. The 5th sample reads addresses 0,3,2,1.
